// File: rtl/gpio_in_cond_if.sv
// Pad-input conditioning bundle: raw pads and configuration toward the
// conditioner, synchronized/debounced levels, events and interrupt back.
interface gpio_in_cond_if #(
    parameter int WIDTH    = 22,
    parameter int PRESC_W  = 16,
    parameter int DB_CNT_W = 4
);
    logic [WIDTH-1:0]    pad_i;
    logic [WIDTH-1:0]    db_en;
    logic [PRESC_W-1:0]  db_presc;
    logic [DB_CNT_W-1:0] db_len;
    logic [WIDTH-1:0]    rise_en;
    logic [WIDTH-1:0]    fall_en;
    logic [WIDTH-1:0]    irq_en;
    logic [WIDTH-1:0]    irq_clr;
    logic [WIDTH-1:0]    fn_i;
    logic [WIDTH-1:0]    gpio_i;
    logic [WIDTH-1:0]    rise_evt;
    logic [WIDTH-1:0]    fall_evt;
    logic [WIDTH-1:0]    irq_pend;
    logic                irq;

    modport slave (
        input  pad_i, db_en, db_presc, db_len, rise_en, fall_en, irq_en, irq_clr,
        output fn_i, gpio_i, rise_evt, fall_evt, irq_pend, irq
    );

    modport master (
        output pad_i, db_en, db_presc, db_len, rise_en, fall_en, irq_en, irq_clr,
        input  fn_i, gpio_i, rise_evt, fall_evt, irq_pend, irq
    );
endinterface

// File: rtl/gpio_in_cond.sv
// Pad input conditioning: synchronizer, prescaled per-pin debounce, edge
// detection and sticky interrupt-pending bits with one combined irq line.
module gpio_in_cond #(
    parameter int WIDTH       = 22,
    parameter int SYNC_STAGES = 2,
    parameter int PRESC_W     = 16,
    parameter int DB_CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    gpio_in_cond_if.slave bus
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
    logic [WIDTH-1:0]                   fn_s;
    logic [PRESC_W-1:0]                 presc_q, presc_d;
    logic                               tick_s;
    logic [DB_CNT_W-1:0]                len_eff_s;
    logic [WIDTH-1:0][DB_CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]                   gpio_q, gpio_d;
    logic [WIDTH-1:0]                   rise_q, rise_d;
    logic [WIDTH-1:0]                   fall_q, fall_d;
    logic [WIDTH-1:0]                   pend_q, pend_d;

    assign fn_s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain; the only consumer of the raw pads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pad_i};
        end
    end

    // ">=" rather than "==" so a shrinking db_presc cannot strand the count.
    assign tick_s    = (presc_q >= bus.db_presc);
    assign presc_d   = tick_s ? '0 : presc_q + PRESC_W'(1);
    assign len_eff_s = (bus.db_len == '0) ? DB_CNT_W'(1) : bus.db_len;

    // Per-pin debounce and next conditioned level.
    always_comb begin
        gpio_d = gpio_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!bus.db_en[i]) begin
                gpio_d[i] = fn_s[i];
                cnt_d[i]  = '0;
            end else if (fn_s[i] == gpio_q[i]) begin
                cnt_d[i]  = '0;
            end else if (tick_s) begin
                if ((cnt_q[i] + DB_CNT_W'(1)) >= len_eff_s) begin
                    gpio_d[i] = fn_s[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i]  = cnt_q[i] + DB_CNT_W'(1);
                end
            end else begin
                cnt_d[i]  = cnt_q[i];
            end
        end
    end

    assign rise_d = gpio_d & ~gpio_q;
    assign fall_d = ~gpio_d & gpio_q;
    // Set has priority over a simultaneous write-1-to-clear.
    assign pend_d = (pend_q & ~bus.irq_clr) | (rise_q & bus.rise_en) | (fall_q & bus.fall_en);

    // Conditioning state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            gpio_q  <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            gpio_q  <= gpio_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.fn_i     = fn_s;
    assign bus.gpio_i   = gpio_q;
    assign bus.rise_evt = rise_q;
    assign bus.fall_evt = fall_q;
    assign bus.irq_pend = pend_q;
    assign bus.irq      = |(pend_q & bus.irq_en);

endmodule

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
Input-side conditioning for the 22 IO pads. It sits between the raw pad inputs and the iomux/GPIO consumers, in the opposite direction to the output mux. Per pin it provides a multi-stage synchronizer, an optional prescaled debounce filter, and rising/falling edge detection. Edge events set sticky interrupt-pending bits, which drive one combined interrupt line.

Parameters:
WIDTH, 22, number of pads handled
SYNC_STAGES, 2, synchronizer flop depth; must be >= 2
PRESC_W, 16, width of the debounce prescaler compare value
DB_CNT_W, 4, width of the per-pin debounce stability counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pad_i  in  WIDTH  raw asynchronous pad inputs
db_en  in  WIDTH  per-pin debounce enable
db_presc  in  PRESC_W  debounce tick period minus one, in clk cycles
db_len  in  DB_CNT_W  stable ticks required before accepting a new level
rise_en  in  WIDTH  per-pin rising-edge pending enable
fall_en  in  WIDTH  per-pin falling-edge pending enable
irq_en  in  WIDTH  per-pin interrupt output mask
irq_clr  in  WIDTH  per-pin pending-clear pulse, write-1-to-clear
fn_i  out  WIDTH  synchronized pad value (not debounced), for alternate functions
gpio_i  out  WIDTH  conditioned pad value (synchronized, optionally debounced)
rise_evt  out  WIDTH  one-cycle pulse on a gpio_i 0->1 transition
fall_evt  out  WIDTH  one-cycle pulse on a gpio_i 1->0 transition
irq_pend  out  WIDTH  sticky pending bits
irq  out  1  OR over (irq_pend & irq_en)

Behaviour:
- Reset (async assert, sync release in the clock domain): all sync flops, gpio_i, fn_i, rise_evt, fall_evt, irq_pend, prescaler and debounce counters are 0; irq is 0.
- Synchronizer: fn_i is the last stage of the SYNC_STAGES chain, SYNC_STAGES cycles after a pad change. No other logic reads pad_i.
- Non-debounced path (db_en[i]=0): gpio_i[i] is a register of fn_i[i], so total latency is SYNC_STAGES+1.
- Prescaler: a free-running counter from 0 to db_presc, then wraps to 0. A tick occurs in the cycle where count==db_presc. db_presc=0 gives a tick every cycle.
- Debounce (db_en[i]=1), with a per-pin counter:
  - fn_i[i]==gpio_i[i]: the counter clears in that cycle (tick or not).
  - fn_i[i]!=gpio_i[i] on a tick: the counter increments.
  - On the tick where the counter would reach max(db_len,1), gpio_i[i] loads fn_i[i] at that edge and the counter clears.
  - The counter never exceeds db_len.
- db_en[i] falling mid-count: the counter clears and gpio_i[i] follows fn_i[i] on the next edge. db_en rising: the counter starts from 0.
- Edge events are registered together with gpio_i:
  - rise_evt[i]=1 for exactly the cycle in which gpio_i[i] first reads 1 after reading 0.
  - fall_evt[i] likewise for the 1->0 transition.
- Pad high during reset: after release it produces one rise_evt once it propagates. This is intended; software clears the pending bit after configuring.
- Pending bits:
  - irq_pend[i] sets on the edge after (rise_evt[i]&rise_en[i]) | (fall_evt[i]&fall_en[i]).
  - It clears on the edge where irq_clr[i]=1.
  - Simultaneous set and clear: set wins.
  - irq_en does not affect irq_pend.
- irq is combinational from irq_pend & irq_en, with no added latency.
- Pins are fully independent apart from the shared prescaler.

Test Plan:
- Reset with pad_i=0: all outputs 0. Release; db_en=0, rise_en[3]=irq_en[3]=1, pad_i[3] 0->1 at cycle 10 -> fn_i[3]=1 at cycle 12; gpio_i[3]=1 and rise_evt[3] single pulse at 13; irq_pend[3]=1 and irq=1 at 14.
- Debounce: db_en[5]=1, db_presc=3, db_len=4.
  - A 10-cycle 1-glitch on pad_i[5] -> gpio_i[5] stays 0 and no events.
  - A stable 1 -> gpio_i[5] rises 13-17 cycles after fn_i[5] rises, with exactly one rise_evt.
- Priority: irq_pend[0]=1, fall_en[0]=1. A fall_evt[0] in the same cycle as irq_clr[0]=1 -> pend stays 1. irq_clr[0] alone next cycle -> pend=0, irq=0.
- Masking: rise_en[7]=0, fall_en[7]=1; toggle pad 0->1->0 -> only the fall sets irq_pend[7]. With irq_en[7]=0, irq=0 while pend=1; set irq_en[7] -> irq=1 in the same cycle.
- Reset mid-debounce: counter at 2 of db_len=4, assert rst asynchronously -> gpio_i, irq_pend, irq go 0 without a clock. After release with pad still high, acceptance again needs the full 4 ticks.
- db_en[2] dropped while counting with fn_i[2]=1, gpio_i[2]=0 -> gpio_i[2]=1 and rise_evt[2] pulse on the next edge.
